// File: rtl/div_unit_m1_pkg.sv
// Shared types for the iterative divider: issue request struct, op and FSM encodings.
package div_unit_m1_pkg;

    localparam int DIV_W     = 16;
    localparam int DIV_STEPS = 16;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10,
        DONE  = 2'b11
    } div_state_e;

    typedef struct packed {
        logic             call;
        logic [1:0]       op;
        logic [3:0]       dest_addr;
        logic [DIV_W-1:0] data1;
        logic [DIV_W-1:0] data2;
    } seq_if_t;

    function automatic logic [DIV_W-1:0] neg_w(input logic [DIV_W-1:0] v);
        return ~v + {{(DIV_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_step_m1.sv
// One restoring division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step_m1
    import div_unit_m1_pkg::*;
#(
    parameter int DATA_W = DIV_W
) (
    input  logic [2*DATA_W-1:0] rq_in,
    input  logic [DATA_W-1:0]   dvs,
    output logic [2*DATA_W-1:0] rq_out
);

    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] diff;

    // Shifted partial remainder is one bit wider than the divisor so the trial never wraps.
    assign shifted = rq_in[2*DATA_W-1:DATA_W-1];
    assign diff    = {1'b0, shifted} - {2'b00, dvs};

    always_comb begin
        rq_out = {shifted[DATA_W-1:0], rq_in[DATA_W-2:0], 1'b0};
        if (!diff[DATA_W+1]) begin
            rq_out = {diff[DATA_W-1:0], rq_in[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit_m1.sv
// Iterative radix-2 restoring divider on the DIV issue port, results returned via req/ack.
module div_unit_m1
    import div_unit_m1_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  seq_if_t           div_in,
    output logic              div_busy,
    output logic              wb_req,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic              wb_ack
);

    div_state_e        state, state_next;
    logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
    logic [3:0]        cnt_q;
    logic [3:0]        dest_q;
    logic              rem_sel_q, q_neg_q, r_neg_q, dvs_zero_q;

    div_op_e           in_op;
    logic              in_signed, in_zero, in_ovf, in_special, accept;
    logic [DATA_W-1:0] a_mag, b_mag, early_data, quo_res, rem_res;
    logic [2*DATA_W-1:0] rq_next;

    assign in_op      = div_op_e'(div_in.op);
    assign in_signed  = (in_op == DIV) || (in_op == REM);
    assign in_zero    = (div_in.data2 == '0);
    assign in_ovf     = in_signed && (div_in.data1 == 16'h8000) && (div_in.data2 == 16'hFFFF);
    assign in_special = in_zero || in_ovf;
    assign accept     = (state == IDLE) && div_in.call;
    assign a_mag      = (in_signed && div_in.data1[DATA_W-1]) ? neg_w(div_in.data1) : div_in.data1;
    assign b_mag      = (in_signed && div_in.data2[DATA_W-1]) ? neg_w(div_in.data2) : div_in.data2;

    always_comb begin
        early_data = in_zero ? 16'hFFFF : 16'h8000;
        if (in_op == REM || in_op == REMU) begin
            early_data = in_zero ? div_in.data1 : '0;
        end
    end

    // Divide-by-zero forces all-ones quotient regardless of operand signs.
    assign quo_res = dvs_zero_q ? 16'hFFFF : (q_neg_q ? neg_w(quo_q) : quo_q);
    assign rem_res = r_neg_q ? neg_w(rem_q) : rem_q;

    div_step_m1 #(.DATA_W(DATA_W)) u_step (
        .rq_in  ({rem_q, quo_q}),
        .dvs    (dvs_q),
        .rq_out (rq_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (div_in.call) state_next = (EARLY_OUT && in_special) ? DONE : CALC;
            CALC:    if (cnt_q == 4'd0) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    if (wb_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        div_busy = (state != IDLE);
        wb_req   = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            dest_q     <= '0;
            rem_sel_q  <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dvs_zero_q <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rem_q      <= '0;
                    quo_q      <= a_mag;
                    dvs_q      <= b_mag;
                    cnt_q      <= 4'(DIV_STEPS - 1);
                    dest_q     <= div_in.dest_addr;
                    rem_sel_q  <= div_in.op[1];
                    q_neg_q    <= in_signed && (div_in.data1[DATA_W-1] ^ div_in.data2[DATA_W-1]);
                    r_neg_q    <= in_signed && div_in.data1[DATA_W-1];
                    dvs_zero_q <= in_zero;
                    if (EARLY_OUT && in_special) begin
                        wb_data <= early_data;
                        wb_addr <= div_in.dest_addr;
                    end
                end
                CALC: begin
                    {rem_q, quo_q} <= rq_next;
                    cnt_q          <= cnt_q - 4'd1;
                end
                FIXUP: begin
                    wb_data <= rem_sel_q ? rem_res : quo_res;
                    wb_addr <= dest_q;
                end
                default: ;
            endcase
        end
    end

    a_no_call_busy : assert property (@(posedge clk) disable iff (rst)
        !(div_in.call && state != IDLE))
        else $error("div_unit_m1: DIV call issued while unit busy");

endmodule

// File: tb/tb_div_unit_m1.sv
// Bench for div_unit_m1: one instance with early-out, one without, checked against an arithmetic model.
module tb_div_unit_m1;
    import div_unit_m1_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    seq_if_t     in_f, in_s;
    logic        ack_f, ack_s;
    logic        busy_f, busy_s, req_f, req_s;
    logic [3:0]  addr_f, addr_s;
    logic [15:0] data_f, data_s;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    div_unit_m1 #(.DATA_W(16), .EARLY_OUT(1'b1)) dut_fast (
        .clk(clk), .rst(rst), .div_in(in_f), .div_busy(busy_f), .wb_req(req_f),
        .wb_addr(addr_f), .wb_data(data_f), .wb_ack(ack_f)
    );

    div_unit_m1 #(.DATA_W(16), .EARLY_OUT(1'b0)) dut_slow (
        .clk(clk), .rst(rst), .div_in(in_s), .div_busy(busy_s), .wb_req(req_s),
        .wb_addr(addr_s), .wb_data(data_s), .wb_ack(ack_s)
    );

    // Reference: plain integer arithmetic plus the two architected special cases.
    function automatic logic [15:0] ref_div(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00: begin
                if (b == 0) return 16'hFFFF;
                if (a == 16'h8000 && b == 16'hFFFF) return 16'h8000;
                return 16'(sa / sb);
            end
            2'b01: return (b == 0) ? 16'hFFFF : a / b;
            2'b10: begin
                if (b == 0) return a;
                if (a == 16'h8000 && b == 16'hFFFF) return 16'h0000;
                return 16'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input bit slow, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        bit special;
        special = (b == 0) || (!op[0] && a == 16'h8000 && b == 16'hFFFF);
        return (special && !slow) ? 0 : 17;
    endfunction

    function automatic logic get_req(input bit slow);   return slow ? req_s  : req_f;  endfunction
    function automatic logic get_busy(input bit slow);  return slow ? busy_s : busy_f; endfunction
    function automatic logic [15:0] get_data(input bit slow); return slow ? data_s : data_f; endfunction
    function automatic logic [3:0]  get_addr(input bit slow); return slow ? addr_s : addr_f; endfunction

    task automatic drive(input bit slow, input seq_if_t r);
        if (slow) in_s = r; else in_f = r;
    endtask

    task automatic set_ack(input bit slow, input logic v);
        if (slow) ack_s = v; else ack_f = v;
    endtask

    // Issues one op, waits for wb_req (latency counted in edges after the accept edge),
    // holds ack low for 'hold' cycles, then acks and samples the unit one cycle later.
    task automatic run_op(input bit slow, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] rd, input int hold, input bit noisy,
                          output logic [15:0] data, output logic [3:0] addr, output int lat,
                          output bit stable, output logic busy_after, output logic req_after);
        seq_if_t r;
        r.call = 1'b1; r.op = op; r.dest_addr = rd; r.data1 = a; r.data2 = b;
        @(negedge clk);
        drive(slow, r);
        @(posedge clk); #1;
        r.call = 1'b0;
        drive(slow, r);
        lat = 0;
        stable = 1'b1;
        while (get_req(slow) !== 1'b1 && lat <= 40) begin
            set_ack(slow, noisy && lat < 5);
            @(posedge clk); #1;
            lat++;
        end
        set_ack(slow, 1'b0);
        if (get_req(slow) !== 1'b1) begin
            lat = -1; data = 'x; addr = 'x; busy_after = 1'bx; req_after = 1'bx;
            return;
        end
        data = get_data(slow);
        addr = get_addr(slow);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (get_req(slow) !== 1'b1 || get_busy(slow) !== 1'b1 ||
                get_data(slow) !== data || get_addr(slow) !== addr) stable = 1'b0;
        end
        set_ack(slow, 1'b1);
        @(posedge clk); #1;
        set_ack(slow, 1'b0);
        busy_after = get_busy(slow);
        req_after  = get_req(slow);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (busy_f !== 1'b0) $display("FAIL reset_busy_f got %0b want 0", busy_f); else n_pass++;
        n_total++; if (req_f !== 1'b0)  $display("FAIL reset_req_f got %0b want 0", req_f); else n_pass++;
        n_total++; if (addr_f !== 4'h0) $display("FAIL reset_addr_f got %h want 0", addr_f); else n_pass++;
        n_total++; if (data_f !== 16'h0) $display("FAIL reset_data_f got %h want 0", data_f); else n_pass++;
        n_total++; if ({busy_s, req_s} !== 2'b00) $display("FAIL reset_slow got %b want 00", {busy_s, req_s}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          slow;
        logic [1:0]  op;
        logic [15:0] a, b;
        logic [3:0]  rd;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    task automatic test_directed;
        vec_t vecs[$];
        logic [15:0] d; logic [3:0] ad; int lat; bit st; logic ba, ra;
        vecs.push_back('{0, 2'b00, 16'd100,  16'd7,      4'd5,  16'h000E, 17});
        vecs.push_back('{0, 2'b10, 16'd100,  16'd7,      4'd5,  16'h0002, 17});
        vecs.push_back('{0, 2'b00, 16'hFFF9, 16'h0002,   4'd3,  16'hFFFD, 17});
        vecs.push_back('{0, 2'b10, 16'hFFF9, 16'h0002,   4'd3,  16'hFFFF, 17});
        vecs.push_back('{0, 2'b01, 16'hFFFF, 16'h0002,   4'd7,  16'h7FFF, 17});
        vecs.push_back('{0, 2'b11, 16'hFFFF, 16'h0002,   4'd7,  16'h0001, 17});
        vecs.push_back('{0, 2'b00, 16'h1234, 16'h0000,   4'd1,  16'hFFFF, 0});
        vecs.push_back('{0, 2'b10, 16'h1234, 16'h0000,   4'd2,  16'h1234, 0});
        vecs.push_back('{0, 2'b01, 16'h1234, 16'h0000,   4'd4,  16'hFFFF, 0});
        vecs.push_back('{1, 2'b00, 16'h1234, 16'h0000,   4'd1,  16'hFFFF, 17});
        vecs.push_back('{1, 2'b10, 16'h1234, 16'h0000,   4'd2,  16'h1234, 17});
        vecs.push_back('{1, 2'b00, 16'hFFF9, 16'h0000,   4'd6,  16'hFFFF, 17});
        vecs.push_back('{0, 2'b00, 16'h8000, 16'hFFFF,   4'd8,  16'h8000, 0});
        vecs.push_back('{0, 2'b10, 16'h8000, 16'hFFFF,   4'd9,  16'h0000, 0});
        vecs.push_back('{0, 2'b01, 16'h8000, 16'hFFFF,   4'd10, 16'h0000, 17});
        vecs.push_back('{1, 2'b00, 16'h8000, 16'hFFFF,   4'd11, 16'h8000, 17});
        vecs.push_back('{1, 2'b10, 16'h8000, 16'hFFFF,   4'd12, 16'h0000, 17});
        foreach (vecs[i]) begin
            run_op(vecs[i].slow, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 0, 1'b1, d, ad, lat, st, ba, ra);
            n_total++; if (lat !== vecs[i].lat) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, vecs[i].lat); else n_pass++;
            n_total++; if (d !== vecs[i].exp) $display("FAIL dir%0d_data got %h want %h", i, d, vecs[i].exp); else n_pass++;
            n_total++; if (ad !== vecs[i].rd) $display("FAIL dir%0d_addr got %h want %h", i, ad, vecs[i].rd); else n_pass++;
            n_total++; if ({ba, ra} !== 2'b00) $display("FAIL dir%0d_release got busy,req=%b want 00", i, {ba, ra}); else n_pass++;
        end
    endtask

    task automatic test_hold;
        logic [15:0] d; logic [3:0] ad; int lat; bit st; logic ba, ra;
        run_op(1'b0, 2'b00, 16'd1000, 16'd3, 4'd9, 5, 1'b0, d, ad, lat, st, ba, ra);
        n_total++; if (st !== 1'b1) $display("FAIL hold_stable got %0b want 1", st); else n_pass++;
        n_total++; if (d !== 16'd333) $display("FAIL hold_data got %h want %h", d, 16'd333); else n_pass++;
        n_total++; if (ad !== 4'd9) $display("FAIL hold_addr got %h want 9", ad); else n_pass++;
        n_total++; if ({ba, ra} !== 2'b00) $display("FAIL hold_release got %b want 00", {ba, ra}); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] d; logic [3:0] ad; int lat; bit st; logic ba, ra;
        run_op(1'b0, 2'b01, 16'd5000, 16'd9, 4'd2, 0, 1'b0, d, ad, lat, st, ba, ra);
        n_total++; if (d !== 16'd555) $display("FAIL b2b_first_data got %h want %h", d, 16'd555); else n_pass++;
        run_op(1'b0, 2'b11, 16'd5000, 16'd9, 4'd3, 0, 1'b0, d, ad, lat, st, ba, ra);
        n_total++; if (lat !== 17) $display("FAIL b2b_second_latency got %0d want 17", lat); else n_pass++;
        n_total++; if (d !== 16'd5) $display("FAIL b2b_second_data got %h want 5", d); else n_pass++;
        n_total++; if (ad !== 4'd3) $display("FAIL b2b_second_addr got %h want 3", ad); else n_pass++;
    endtask

    task automatic test_reset_mid;
        seq_if_t r;
        bit seen;
        logic [15:0] d; logic [3:0] ad; int lat; bit st; logic ba, ra;
        r.call = 1'b1; r.op = 2'b00; r.dest_addr = 4'd6; r.data1 = 16'd700; r.data2 = 16'd3;
        @(negedge clk);
        in_f = r;
        @(posedge clk); #1;
        r.call = 1'b0;
        in_f = r;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if (busy_f !== 1'b0) $display("FAIL midrst_busy got %0b want 0", busy_f); else n_pass++;
        n_total++; if (req_f !== 1'b0) $display("FAIL midrst_req got %0b want 0", req_f); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (req_f !== 1'b0 || busy_f !== 1'b0) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL midrst_no_result got %0b want 0", seen); else n_pass++;
        run_op(1'b0, 2'b10, 16'd700, 16'd3, 4'd6, 0, 1'b0, d, ad, lat, st, ba, ra);
        n_total++; if (d !== 16'd1 || lat !== 17) $display("FAIL midrst_fresh got data=%h lat=%0d want data=1 lat=17", d, lat); else n_pass++;
    endtask

    task automatic test_random;
        logic [15:0] a, b, d; logic [1:0] op; logic [3:0] rd, ad; int lat; bit st; logic ba, ra;
        for (int i = 0; i < 60; i++) begin
            bit slow;
            slow = i[0];
            op = 2'($urandom_range(0, 3));
            rd = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0: a = 16'h0000;
                1: a = 16'h8000;
                2: a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: b = 16'h0000;
                1: b = 16'hFFFF;
                2: b = 16'h0001;
                3: b = 16'($urandom_range(1, 20));
                4: b = 16'hFFFF - 16'($urandom_range(0, 20));
                default: b = 16'($urandom);
            endcase
            run_op(slow, op, a, b, rd, $urandom_range(0, 2), 1'($urandom_range(0, 1)), d, ad, lat, st, ba, ra);
            n_total++;
            if (lat !== ref_lat(slow, op, a, b) || d !== ref_div(op, a, b) || ad !== rd || st !== 1'b1)
                $display("FAIL rnd%0d slow=%0b op=%0d a=%h b=%h got data=%h addr=%h lat=%0d want data=%h addr=%h lat=%0d",
                         i, slow, op, a, b, d, ad, lat, ref_div(op, a, b), rd, ref_lat(slow, op, a, b));
            else n_pass++;
        end
    endtask

    initial begin
        in_f  = '0;
        in_s  = '0;
        ack_f = 1'b0;
        ack_s = 1'b0;
        test_reset;
        test_directed;
        test_hold;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_unit_m1.md
Name: div_unit_m1

Overview:
- Iterative 16-bit integer divider on the issue stage's DIV port.
- Receives `seq_if_t` requests (call, op, dest_addr, data1, data2) and reports `div_busy` back to the issue stage, which stalls new DIV calls while it is high.
- Returns quotient or remainder to the writeback arbiter through a req/ack handshake.
- Restoring radix-2 algorithm, one quotient bit per cycle; zero-divisor and signed-overflow cases short-circuit.

Parameters:
- DATA_W, 16, operand/result width; only 16 is supported.
- EARLY_OUT, 1, 1 = divide-by-zero and signed overflow skip CALC and go straight to DONE; 0 = they run the full iteration sequence and still produce the same results.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- div_in  in  seq_if_t  issue request. data1 = dividend (rs1), data2 = divisor (rs2), op = func4[1:0], dest_addr = rd
- div_busy  out  1  high whenever the unit holds an operation (state != IDLE)
- wb_req  out  1  result valid for writeback
- wb_addr  out  4  destination register of the result
- wb_data  out  16  result
- wb_ack  in  1  writeback arbiter accepted the result this cycle

Behaviour:
- Clock and reset:
  - One clock `clk`; reset `rst` is synchronous and active-high.
  - Reset values: state = IDLE, `div_busy` = 0, `wb_req` = 0, `wb_addr` = 0, `wb_data` = 0, all internal registers 0.
- Op encoding (`op`):
  - 00 DIV: signed quotient.
  - 01 DIVU: unsigned quotient.
  - 10 REM: signed remainder.
  - 11 REMU: unsigned remainder.
- Accept: in IDLE with `div_in.call` = 1 at cycle T, latch op, dest_addr, operand magnitudes, and the sign of quotient and remainder. `div_busy` = 1 from T+1.
- `div_in.call` while not IDLE is ignored, and a simulation assertion fires; the issue stage must never do this.
- States:
  - IDLE → CALC on accept.
  - IDLE → DONE on accept when EARLY_OUT=1 and the operation is a special case.
  - CALC: 16 cycles (T+1..T+16). Step counter runs 15 down to 0. Each cycle: shift {rem, quo} left by 1, trial-subtract |divisor|, set the quotient bit when the difference is non-negative.
  - CALC → FIXUP when the counter reaches 0.
  - FIXUP (T+17): apply signs and select quotient or remainder. Registers `wb_data` and `wb_addr`. Transition → DONE.
  - DONE (from T+18, or from T+1 for an early-out): `wb_req` = 1. `wb_data` and `wb_addr` are held stable until `wb_ack`. On `wb_ack` → IDLE, and `wb_req` and `div_busy` drop next cycle.
  - A new call may be accepted the cycle after returning to IDLE. Minimum spacing between calls is 19 cycles without early-out.
- Sign rules:
  - Signed ops work on magnitudes.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
- Special cases:
  - Divisor 0: quotient = 0xFFFF, remainder = dividend.
  - Signed 0x8000 / 0xFFFF: quotient = 0x8000, remainder = 0.
- `wb_ack` while `wb_req` = 0 is ignored.
- Reset mid-operation: the operation is discarded, state goes to IDLE, and `wb_req` is never raised for it.
- No flush input: an issued DIV has already reserved its destination register and must complete.

Decomposition:
- In Types_m1 (shared package):
  - Add enum `div_op_e` {DIV, DIVU, REM, REMU}.
  - Add enum `div_state_e` {IDLE, CALC, FIXUP, DONE}.
  - Add constant DIV_STEPS = 16.
  - Reuse the existing `seq_if_t`.
- One sub-module, `div_step_m1`: purely combinational single restoring iteration.
  - Inputs: {rem, quo}, divisor magnitude.
  - Outputs: next {rem, quo}.
  - Keeps the FSM file free of datapath arithmetic and allows a future 2-step unroll.

Test Plan:
- DIV 100 / 7, dest 5 → `wb_req` at T+18, `wb_data` 0x000E, `wb_addr` 5. REM on the same operands → 0x0002.
- DIV 0xFFF9 (-7) / 0x0002 → 0xFFFD (-3). REM → 0xFFFF (-1). DIVU 0xFFFF / 0x0002 → 0x7FFF. REMU → 0x0001.
- Divisor 0, dividend 0x1234 (EARLY_OUT=1):
  - DIV → 0xFFFF with `wb_req` at T+1.
  - REM → 0x1234.
  - Repeat with EARLY_OUT=0 → same values at T+18.
- Signed overflow DIV 0x8000 / 0xFFFF → 0x8000. REM → 0x0000. DIVU on the same operands → 0x0000.
- Hold `wb_ack` low 5 cycles after `wb_req` rises → `wb_req`, `wb_data`, `wb_addr` and `div_busy` stable. Ack → `div_busy` 0 next cycle, new call accepted. A call injected while busy → no effect, assertion fires.
- Assert `rst` at T+8 mid-CALC → next cycle `div_busy` = 0 and `wb_req` = 0. No result appears afterwards. A fresh call completes correctly.
